i2c_master_ctrl: RTL and testbench

//  Sequencer for the I2C master datapath. Accepts a transfer request (7-bit address, R/W, byte count),

---
 rtl/i2c_pkg.sv | 39 +++
 rtl/i2c_bit_counter.sv | 28 ++
 rtl/i2c_master_ctrl.sv | 176 +++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C phase codes and per-phase pin drive, used by the sequencer and the datapath.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package i2c_pkg;

    localparam logic [7:0] ST_IDLE       = 8'd0;
    localparam logic [7:0] ST_START      = 8'd1;
    localparam logic [7:0] ST_ADDRESS    = 8'd2;
    localparam logic [7:0] ST_READ_ACK   = 8'd3;
    localparam logic [7:0] ST_WRITE_DATA = 8'd4;
    localparam logic [7:0] ST_READ_ACK2  = 8'd5;
    localparam logic [7:0] ST_READ_DATA  = 8'd6;
    localparam logic [7:0] ST_WRITE_ACK2 = 8'd7;
    localparam logic [7:0] ST_STOP       = 8'd8;

    // Bit index of the first (MSB) bit of every shifted byte.
    localparam logic [3:0] BIT_TOP = 4'd7;

    // Pin drive for a phase, returned as {scl_en, write_en}.
    // SCL is held high only around START/STOP and while idle. The master
    // owns SDA for START, address, write data, its own ACK and STOP.
    function automatic logic [1:0] phase_drive(input logic [7:0] st);
        logic [1:0] drv;
        case (st)
            ST_IDLE:       drv = 2'b10;
            ST_START:      drv = 2'b11;
            ST_ADDRESS:    drv = 2'b01;
            ST_READ_ACK:   drv = 2'b00;
            ST_WRITE_DATA: drv = 2'b01;
            ST_READ_ACK2:  drv = 2'b00;
            ST_READ_DATA:  drv = 2'b00;
            ST_WRITE_ACK2: drv = 2'b01;
            ST_STOP:       drv = 2'b11;
            default:       drv = 2'b10;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/i2c_bit_counter.sv
// Bit index counter for byte shifting: loads 7, counts down, flags bit 0.
// Latency: load/decrement take effect on the next clock; last is combinational from count.
// Backpressure: none; load has priority over dec.
// Ports: clk, rst (async, active high), load, dec -> count[3:0], last (count == 0).
module i2c_bit_counter
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] count,
    output logic       last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= BIT_TOP;
        end else if (load) begin
            count <= BIT_TOP;
        end else if (dec) begin
            count <= count - 4'd1;
        end
    end

    assign last = (count == 4'd0);

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master sequencer: walks START/ADDRESS/ACK/DATA/ACK/STOP and drives the datapath phase.
// Latency: accept -> first address bit 2 cycles; write of N bytes takes 12+9N cycles IDLE->IDLE.
// Backpressure: req is only taken while idle; a req during a transfer is dropped, not queued.
// Ports: i2c_scl_in (bit clock), reset; req/req_addr/req_rw/req_nbytes host request; SDA_in ACK
//   sample; state/count/i2c_scl_en/i2c_write_en/mst_ack/rw/addr to datapath; tx_next/rx_valid
//   byte strobes; busy, done pulse, sticky nack_err status.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int NB_W = 4
) (
    input  logic            i2c_scl_in,
    input  logic            reset,
    input  logic            req,
    input  logic [6:0]      req_addr,
    input  logic            req_rw,
    input  logic [NB_W-1:0] req_nbytes,
    input  logic            SDA_in,
    output logic [7:0]      state,
    output logic [3:0]      count,
    output logic            i2c_scl_en,
    output logic            i2c_write_en,
    output logic            mst_ack,
    output logic            rw,
    output logic [6:0]      addr,
    output logic            tx_next,
    output logic            rx_valid,
    output logic            busy,
    output logic            done,
    output logic            nack_err
);

    localparam logic [NB_W-1:0] ONE = {{(NB_W-1){1'b0}}, 1'b1};

    logic [NB_W-1:0] bytes_left;
    logic [NB_W-1:0] nxt_bytes;
    logic [7:0]      nxt_state;
    logic [6:0]      nxt_addr;
    logic            nxt_rw;
    logic            nxt_busy;
    logic            nxt_nack;
    logic            nxt_tx;
    logic            nxt_rx;
    logic            nxt_done;
    logic            nxt_mst_ack;
    logic            shifting;
    logic            bit_last;
    logic            cnt_dec;
    logic            cnt_load;

    // count walks 7..0 only while a byte is being shifted and sits at 7
    // everywhere else, so the datapath always sees the MSB index first.
    assign cnt_dec  = shifting && !bit_last;
    assign cnt_load = !cnt_dec;

    i2c_bit_counter u_bit_counter (
        .clk   (i2c_scl_in),
        .rst   (reset),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .count (count),
        .last  (bit_last)
    );

    always_comb begin
        nxt_state = state;
        nxt_addr  = addr;
        nxt_rw    = rw;
        nxt_busy  = busy;
        nxt_nack  = nack_err;
        nxt_bytes = bytes_left;
        nxt_tx    = 1'b0;
        nxt_rx    = 1'b0;
        nxt_done  = 1'b0;
        shifting  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req && !busy) begin
                    nxt_addr  = req_addr;
                    nxt_rw    = req_rw;
                    nxt_bytes = (req_nbytes == '0) ? ONE : req_nbytes;
                    nxt_busy  = 1'b1;
                    nxt_nack  = 1'b0;
                    nxt_state = ST_START;
                end
            end
            ST_START: nxt_state = ST_ADDRESS;
            ST_ADDRESS: begin
                shifting = 1'b1;
                if (bit_last) nxt_state = ST_READ_ACK;
            end
            ST_READ_ACK: begin
                if (SDA_in) begin
                    nxt_nack  = 1'b1;
                    nxt_state = ST_STOP;
                end else if (rw) begin
                    nxt_state = ST_READ_DATA;
                end else begin
                    nxt_state = ST_WRITE_DATA;
                    nxt_tx    = 1'b1;
                end
            end
            ST_WRITE_DATA: begin
                shifting = 1'b1;
                if (bit_last) nxt_state = ST_READ_ACK2;
            end
            ST_READ_ACK2: begin
                if (bytes_left != '0) nxt_bytes = bytes_left - ONE;
                if (SDA_in) begin
                    nxt_nack  = 1'b1;
                    nxt_state = ST_STOP;
                end else if (bytes_left > ONE) begin
                    // More than one byte was left before this ACK: send another.
                    nxt_state = ST_WRITE_DATA;
                    nxt_tx    = 1'b1;
                end else begin
                    nxt_state = ST_STOP;
                end
            end
            ST_READ_DATA: begin
                shifting = 1'b1;
                if (bit_last) begin
                    nxt_state = ST_WRITE_ACK2;
                    nxt_rx    = 1'b1;
                end
            end
            ST_WRITE_ACK2: begin
                if (bytes_left != '0) nxt_bytes = bytes_left - ONE;
                nxt_state = (bytes_left > ONE) ? ST_READ_DATA : ST_STOP;
            end
            ST_STOP: begin
                nxt_state = ST_IDLE;
                nxt_busy  = 1'b0;
                nxt_done  = 1'b1;
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_busy  = 1'b0;
            end
        endcase
        // Master NACKs the final read byte so the slave releases SDA before STOP.
        nxt_mst_ack = (nxt_state == ST_WRITE_ACK2) ? (bytes_left == ONE) : 1'b1;
    end

    // Outputs are registered from the next state so pin drive and strobes
    // line up exactly with the phase code seen by the datapath.
    always_ff @(posedge i2c_scl_in or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            i2c_scl_en   <= 1'b1;
            i2c_write_en <= 1'b0;
            mst_ack      <= 1'b1;
            rw           <= 1'b0;
            addr         <= 7'd0;
            tx_next      <= 1'b0;
            rx_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            nack_err     <= 1'b0;
            bytes_left   <= '0;
        end else begin
            state                      <= nxt_state;
            {i2c_scl_en, i2c_write_en} <= phase_drive(nxt_state);
            mst_ack                    <= nxt_mst_ack;
            rw                         <= nxt_rw;
            addr                       <= nxt_addr;
            tx_next                    <= nxt_tx;
            rx_valid                   <= nxt_rx;
            busy                       <= nxt_busy;
            done                       <= nxt_done;
            nack_err                   <= nxt_nack;
            bytes_left                 <= nxt_bytes;
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: per-cycle expected phase trace queued at request time, popped while busy.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [6:0] req_addr;
    logic       req_rw;
    logic [3:0] req_nbytes;
    logic       sda;
    logic [7:0] state;
    logic [3:0] count;
    logic       scl_en, write_en, mst_ack, rw, tx_next, rx_valid, busy, done, nack_err;
    logic [6:0] addr;

    i2c_master_ctrl #(.NB_W(4)) dut (
        .i2c_scl_in   (clk),
        .reset        (rst),
        .req          (req),
        .req_addr     (req_addr),
        .req_rw       (req_rw),
        .req_nbytes   (req_nbytes),
        .SDA_in       (sda),
        .state        (state),
        .count        (count),
        .i2c_scl_en   (scl_en),
        .i2c_write_en (write_en),
        .mst_ack      (mst_ack),
        .rw           (rw),
        .addr         (addr),
        .tx_next      (tx_next),
        .rx_valid     (rx_valid),
        .busy         (busy),
        .done         (done),
        .nack_err     (nack_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int done_cyc = 0;

    always @(posedge clk) cyc_cnt++;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] st;
        logic [3:0] cnt;
        logic       scl, we, tx, rx, dn, bsy, ne, ma_chk, ma;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_on = 1'b1;
    bit   addr_nack = 1'b0;
    bit   data_nack = 1'b0;

    // Slave model: answers ACK (0) unless told to NACK the address or data.
    assign sda = ((state == 8'd3) && addr_nack) || ((state == 8'd5) && data_nack);

    function automatic void push(input logic [7:0] st, input logic [3:0] cnt, input logic tx,
                                 input logic rx, input logic dn, input logic bsy, input logic ne,
                                 input logic ma_chk, input logic ma);
        exp_t e;
        e.st = st; e.cnt = cnt; e.tx = tx; e.rx = rx; e.dn = dn; e.bsy = bsy; e.ne = ne;
        e.ma_chk = ma_chk; e.ma = ma;
        e.scl = (st == 8'd0) || (st == 8'd1) || (st == 8'd8);
        e.we  = (st == 8'd1) || (st == 8'd2) || (st == 8'd4) || (st == 8'd7) || (st == 8'd8);
        exp_q.push_back(e);
    endfunction

    // Expected phase trace from the cycle after accept through the first IDLE cycle.
    function automatic void build(input logic rd, input int nb, input bit anack, input bit dnack);
        int   n;
        logic ne;
        n  = (nb == 0) ? 1 : nb;
        ne = 1'b0;
        push(8'd1, 4'd7, 0, 0, 0, 1, ne, 0, 0);
        for (int i = 0; i < 8; i++) push(8'd2, 4'(7 - i), 0, 0, 0, 1, ne, 0, 0);
        push(8'd3, 4'd7, 0, 0, 0, 1, ne, 0, 0);
        if (anack) begin
            ne = 1'b1;
        end else if (!rd) begin
            for (int b = 0; b < n; b++) begin
                for (int i = 0; i < 8; i++) push(8'd4, 4'(7 - i), (i == 0), 0, 0, 1, ne, 0, 0);
                push(8'd5, 4'd7, 0, 0, 0, 1, ne, 0, 0);
                if (dnack) begin
                    ne = 1'b1;
                    break;
                end
            end
        end else begin
            for (int b = 0; b < n; b++) begin
                for (int i = 0; i < 8; i++) push(8'd6, 4'(7 - i), 0, 0, 0, 1, ne, 0, 0);
                push(8'd7, 4'd7, 0, 1, 0, 1, ne, 1, (b == n - 1));
            end
        end
        push(8'd8, 4'd7, 0, 0, 0, 1, ne, 0, 0);
        push(8'd0, 4'd7, 0, 0, 1, 0, ne, 0, 0);
    endfunction

    always @(negedge clk) begin
        if (mon_on && (busy || done)) begin
            if (exp_q.size() == 0) begin
                check_val("extra_activity", {30'd0, busy, done}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("state", state, e.st);
                check_val("count", count, e.cnt);
                check_val("scl_en", scl_en, e.scl);
                check_val("write_en", write_en, e.we);
                check_val("tx_next", tx_next, e.tx);
                check_val("rx_valid", rx_valid, e.rx);
                check_val("done", done, e.dn);
                check_val("busy", busy, e.bsy);
                check_val("nack_err", nack_err, e.ne);
                if (e.ma_chk) check_val("mst_ack", mst_ack, e.ma);
                if (e.dn) done_cyc = cyc_cnt;
            end
        end
    end

    // Runs one transfer; poke pulses a conflicting req while busy.
    task automatic xfer(input logic [6:0] a, input logic rd, input logic [3:0] nb,
                        input bit anack, input bit dnack, input bit poke, output int dur);
        int c0;
        @(negedge clk);
        addr_nack  = anack;
        data_nack  = dnack;
        build(rd, nb, anack, dnack);
        req        = 1'b1;
        req_addr   = a;
        req_rw     = rd;
        req_nbytes = nb;
        c0         = cyc_cnt;
        @(negedge clk);
        req = 1'b0;
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            if (poke && k == 3) begin
                req        = 1'b1;
                req_addr   = 7'h11;
                req_rw     = ~rd;
                req_nbytes = 4'd5;
            end
            if (poke && k == 4) req = 1'b0;
        end
        if (exp_q.size() != 0) begin
            check_val("timeout_left", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
        dur = done_cyc - c0;
        check_val("addr_latched", addr, a);
        check_val("rw_latched", rw, rd);
    endtask

    initial begin
        int dur;
        rst = 1'b1; req = 1'b0; req_addr = 7'd0; req_rw = 1'b0; req_nbytes = 4'd0;
        #12;
        check_val("rst_state", state, 8'd0);
        check_val("rst_count", count, 4'd7);
        check_val("rst_scl_en", scl_en, 1'b1);
        check_val("rst_write_en", write_en, 1'b0);
        check_val("rst_mst_ack", mst_ack, 1'b1);
        check_val("rst_flags", {rw, tx_next, rx_valid, busy, done, nack_err}, 6'd0);
        @(negedge clk);
        rst = 1'b0;

        xfer(7'h50, 1'b0, 4'd1, 0, 0, 0, dur);
        check_val("wr1_cycles", dur, 21);
        xfer(7'h50, 1'b0, 4'd3, 0, 0, 0, dur);
        check_val("wr3_cycles", dur, 39);
        xfer(7'h3C, 1'b1, 4'd2, 0, 0, 0, dur);
        xfer(7'h22, 1'b0, 4'd2, 1, 0, 0, dur);
        check_val("addr_nack_sticky", nack_err, 1'b1);
        xfer(7'h23, 1'b0, 4'd2, 0, 1, 0, dur);
        xfer(7'h24, 1'b0, 4'd0, 0, 0, 0, dur);
        check_val("nb0_cycles", dur, 21);
        xfer(7'h50, 1'b0, 4'd1, 0, 0, 1, dur);
        repeat (3) @(negedge clk);
        check_val("ignored_req_idle", {state, 3'd0, busy}, 12'd0);

        // Reset in the middle of a write byte.
        @(negedge clk);
        build(1'b0, 2, 0, 0);
        req = 1'b1; req_addr = 7'h41; req_rw = 1'b0; req_nbytes = 4'd2;
        @(negedge clk);
        req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (state == 8'd4 && count == 4'd4) break;
        end
        check_val("rst_reach_wd4", {state, count}, {8'd4, 4'd4});
        #1;
        mon_on = 1'b0;
        rst = 1'b1;
        #1;
        check_val("midrst_state", state, 8'd0);
        check_val("midrst_scl_en", scl_en, 1'b1);
        check_val("midrst_write_en", write_en, 1'b0);
        check_val("midrst_busy", busy, 1'b0);
        check_val("midrst_count", count, 4'd7);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(negedge clk);
        check_val("no_stop_after_rst", {state, 2'd0, busy, done}, 12'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
